sr_latch_ctrl: RTL and testbench

Sequencing controller and two-port arbiter for a bank of gated SR latches with active-low clear. Two requesters submit set/reset/clear commands over a valid/ready handshake. The block grants them round-robin and drives the bank's S, R, Enable and Clear lines with a fixed setup → enable-pulse → hold sequence. It guarantees the forbidden S=R=1 input never reaches any latch, and keeps a shadow copy of the expected latch contents.

---
 rtl/sr_latch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_ctrl.sv
// Sequencer and round-robin arbiter for a bank of gated SR latches with active-low clear.
// Drives S/R/Enable/Clear with a setup -> pulse -> hold sequence and tracks expected contents.
module sr_latch_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PULSE_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [1:0]       a_op,
  input  logic [WIDTH-1:0] a_mask,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [1:0]       b_op,
  input  logic [WIDTH-1:0] b_mask,
  output logic             b_ready,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             en_out,
  output logic             clr_n_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shadow_q
);

  if (PULSE_W == 0) begin : g_pulse_w_check
    $error("sr_latch_ctrl: PULSE_W must be at least 1");
  end

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpSet   = 2'b01;
  localparam logic [1:0] OpReset = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  localparam int unsigned  CntW    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(PULSE_W - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StClrp, StHold} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic              last_b_q, last_b_d;
  logic              init_q;
  logic              idle_ok, grant_a, grant_b, xfer_a, xfer_b;
  logic [WIDTH-1:0]  s_d, r_d, shadow_d;
  logic              en_d, clr_n_d, busy_d, done_d;

  // No grant in the first cycle after reset release while the bank clear is lifted.
  assign idle_ok = (state_q == StIdle) && !init_q;
  assign grant_a = a_valid && (!b_valid || last_b_q);
  assign grant_b = b_valid && (!a_valid || !last_b_q);
  assign a_ready = idle_ok && grant_a;
  assign b_ready = idle_ok && grant_b;
  assign xfer_a  = a_valid && a_ready;
  assign xfer_b  = b_valid && b_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mask_d   = mask_q;
    last_b_d = last_b_q;
    unique case (state_q)
      StIdle: begin
        if (xfer_a || xfer_b) begin
          op_d     = xfer_a ? a_op : b_op;
          mask_d   = xfer_a ? a_mask : b_mask;
          last_b_d = xfer_b;
          case (op_d)
            OpSet, OpReset: state_d = StSetup;
            OpClear: begin
              state_d = StClrp;
              cnt_d   = CntLoad;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StSetup: begin
        state_d = StPulse;
        cnt_d   = CntLoad;
      end
      StPulse, StClrp: begin
        if (cnt_q == '0) begin
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    s_d      = '0;
    r_d      = '0;
    shadow_d = shadow_q;
    if (state_d inside {StSetup, StPulse, StHold}) begin
      if (op_d == OpSet) begin
        s_d = mask_d;
      end else if (op_d == OpReset) begin
        r_d = mask_d;
      end
    end
    en_d    = (state_d == StPulse);
    clr_n_d = (state_d != StClrp);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StHold);
    if (state_d == StHold && state_q != StHold) begin
      case (op_q)
        OpSet:   shadow_d = shadow_q | mask_q;
        OpReset: shadow_d = shadow_q & ~mask_q;
        OpClear: shadow_d = '0;
        default: shadow_d = shadow_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= OpNop;
      mask_q    <= '0;
      last_b_q  <= 1'b1;
      init_q    <= 1'b1;
      s_out     <= '0;
      r_out     <= '0;
      en_out    <= 1'b0;
      clr_n_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shadow_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mask_q    <= mask_d;
      last_b_q  <= last_b_d;
      init_q    <= 1'b0;
      s_out     <= s_d;
      r_out     <= r_d;
      en_out    <= en_d;
      clr_n_out <= clr_n_d;
      busy      <= busy_d;
      done      <= done_d;
      shadow_q  <= shadow_d;
    end
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed bench for sr_latch_ctrl (WIDTH=8, PULSE_W=2): sequencing, arbitration, shadow, reset.
module tb_sr_latch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [1:0] a_op = 2'b00, b_op = 2'b00;
  logic [7:0] a_mask = 8'h00, b_mask = 8'h00;
  logic       a_ready, b_ready;
  logic [7:0] s_out, r_out, shadow_q;
  logic       en_out, clr_n_out, busy, done;

  int errors = 0;
  int checks = 0;
  int inv_sr = 0, inv_en = 0, inv_rdy = 0, done_cnt = 0;

  sr_latch_ctrl #(.WIDTH(8), .PULSE_W(2)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_op(a_op), .a_mask(a_mask), .a_ready(a_ready),
    .b_valid(b_valid), .b_op(b_op), .b_mask(b_mask), .b_ready(b_ready),
    .s_out(s_out), .r_out(r_out), .en_out(en_out), .clr_n_out(clr_n_out),
    .busy(busy), .done(done), .shadow_q(shadow_q)
  );

  always #5 clk = ~clk;

  // Invariant monitor, sampled mid-low-phase
  always @(negedge clk) begin
    #2;
    if ((s_out & r_out) != 8'h00) inv_sr++;
    if (en_out && !clr_n_out) inv_en++;
    if (a_ready && b_ready) inv_rdy++;
    if (done) done_cnt++;
  end

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (clr_n_out !== 1'b0) begin errors++; $display("FAIL reset_clr_n got %b want 0", clr_n_out); end
    checks++; if ({s_out, r_out, shadow_q} !== 24'h0) begin errors++;
      $display("FAIL reset_data got s=%h r=%h sh=%h want 0", s_out, r_out, shadow_q); end
    checks++; if ({en_out, busy, done} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl got en/busy/done=%b want 000", {en_out, busy, done}); end
    rst = 1'b0;
    a_valid = 1'b1; a_op = 2'b01; a_mask = 8'hFF;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_first_grant got %b want 0", a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    checks++; if (clr_n_out !== 1'b1) begin errors++; $display("FAIL reset_clr_n_rise got %b want 1", clr_n_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_xfer busy got %b want 0", busy); end
  endtask

  task automatic test_set_a();
    logic [7:0] es;
    logic       een, edone, ebusy;
    @(negedge clk);
    a_valid = 1'b1; a_op = 2'b01; a_mask = 8'h0F;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL set_a_ready got %b want 1", a_ready); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      a_valid = 1'b0;
      es    = (k <= 4) ? 8'h0F : 8'h00;
      een   = (k == 2 || k == 3);
      edone = (k == 4);
      ebusy = (k <= 4);
      checks++;
      if (s_out !== es || r_out !== 8'h00 || en_out !== een || done !== edone || busy !== ebusy) begin
        errors++;
        $display("FAIL set_a_T+%0d got s=%h r=%h en=%b done=%b busy=%b want s=%h r=00 en=%b done=%b busy=%b",
                 k, s_out, r_out, en_out, done, busy, es, een, edone, ebusy);
      end
    end
    checks++; if (shadow_q !== 8'h0F) begin errors++; $display("FAIL set_a_shadow got %h want 0f", shadow_q); end
  endtask

  task automatic test_nop_then_tie();
    int dc;
    int n;
    @(negedge clk);
    dc = done_cnt;
    a_valid = 1'b1; a_op = 2'b00; a_mask = 8'hAA;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL nop_ready got %b want 1", a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nop_busy got %b want 0", busy); end
    // Tie after A's nop must go to B
    a_valid = 1'b1; a_op = 2'b01; a_mask = 8'h01;
    b_valid = 1'b1; b_op = 2'b01; b_mask = 8'hFF;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++;
      $display("FAIL nop_tie_grant got a/b=%b want 01", {a_ready, b_ready}); end
    checks++; if (done_cnt !== dc) begin errors++; $display("FAIL nop_done got %0d want %0d", done_cnt, dc); end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    n = 0;
    while (busy && n < 10) begin @(negedge clk); n++; end
    checks++; if (n >= 10) begin errors++; $display("FAIL nop_tie_timeout got busy=%b want 0", busy); end
    checks++; if (shadow_q !== 8'hFF) begin errors++; $display("FAIL nop_tie_shadow got %h want ff", shadow_q); end
  endtask

  task automatic test_clear_b();
    @(negedge clk);
    b_valid = 1'b1; b_op = 2'b11; b_mask = 8'h5A;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL clear_ready got %b want 1", b_ready); end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      b_valid = 1'b0;
      checks++;
      if (clr_n_out !== 1'b0 || en_out !== 1'b0 || s_out !== 8'h00 || r_out !== 8'h00) begin
        errors++;
        $display("FAIL clear_T+%0d got clr_n=%b en=%b s=%h r=%h want 0 0 00 00",
                 k, clr_n_out, en_out, s_out, r_out);
      end
    end
    @(negedge clk);
    checks++;
    if (clr_n_out !== 1'b1 || done !== 1'b1 || en_out !== 1'b0 || shadow_q !== 8'h00) begin
      errors++;
      $display("FAIL clear_hold got clr_n=%b done=%b en=%b sh=%h want 1 1 0 00",
               clr_n_out, done, en_out, shadow_q);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_idle busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int ta = -1;
    int tb = -1;
    logic a_ack, b_ack;
    @(negedge clk);
    a_valid = 1'b1; a_op = 2'b01; a_mask = 8'hF0;
    b_valid = 1'b1; b_op = 2'b10; b_mask = 8'h30;
    for (int c = 0; c < 12; c++) begin
      #1;
      a_ack = a_valid && a_ready;
      b_ack = b_valid && b_ready;
      if (a_ack) ta = c;
      if (b_ack) tb = c;
      @(negedge clk);
      if (a_ack) a_valid = 1'b0;
      if (b_ack) b_valid = 1'b0;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    checks++; if (ta !== 0) begin errors++; $display("FAIL b2b_a_cycle got %0d want 0", ta); end
    checks++; if (tb !== 5) begin errors++; $display("FAIL b2b_b_cycle got %0d want 5", tb); end
    checks++; if (shadow_q !== 8'hC0) begin errors++; $display("FAIL b2b_shadow got %h want c0", shadow_q); end
  endtask

  task automatic test_reset_mid();
    int dc;
    int n;
    @(negedge clk);
    a_valid = 1'b1; a_op = 2'b01; a_mask = 8'hFF;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    checks++; if (en_out !== 1'b1) begin errors++; $display("FAIL rmid_pulse en got %b want 1", en_out); end
    dc = done_cnt;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (en_out !== 1'b0 || s_out !== 8'h00 || clr_n_out !== 1'b0 || busy !== 1'b0 || shadow_q !== 8'h00) begin
      errors++;
      $display("FAIL rmid_async got en=%b s=%h clr_n=%b busy=%b sh=%h want 0 00 0 0 00",
               en_out, s_out, clr_n_out, busy, shadow_q);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (done_cnt !== dc) begin errors++; $display("FAIL rmid_no_done got %0d want %0d", done_cnt, dc); end
    a_valid = 1'b1; a_op = 2'b01; a_mask = 8'h55;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rmid_clean_ready got %b want 1", a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    n = 1;
    while (!done && n < 10) begin @(negedge clk); n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL rmid_clean_done_at got T+%0d want T+4", n); end
    checks++; if (shadow_q !== 8'h55) begin errors++; $display("FAIL rmid_clean_shadow got %h want 55", shadow_q); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_invariants();
    #3;
    checks++; if (inv_sr !== 0) begin errors++; $display("FAIL inv_s_and_r got %0d want 0", inv_sr); end
    checks++; if (inv_en !== 0) begin errors++; $display("FAIL inv_en_clr got %0d want 0", inv_en); end
    checks++; if (inv_rdy !== 0) begin errors++; $display("FAIL inv_ready_pair got %0d want 0", inv_rdy); end
  endtask

  initial begin
    test_reset();
    test_set_a();
    test_nop_then_tie();
    test_clear_b();
    test_back_to_back();
    test_reset_mid();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got time limit want finish");
    $fatal(1, "timeout");
  end

endmodule
